// File: rtl/tank_ctrl_p.sv
// Per-player tank controller: keycode-driven clamped motion and heading,
// rate-limited fire pulse, and a hit -> dying blink -> respawn/game-over
// life cycle. All game state advances once per synchronised frame tick.
module tank_ctrl_p #(
    parameter logic [9:0] X_START      = 10'd500,
    parameter logic [9:0] Y_START      = 10'd240,
    parameter logic [9:0] X_MIN        = 10'd0,
    parameter logic [9:0] X_MAX        = 10'd639,
    parameter logic [9:0] Y_MIN        = 10'd0,
    parameter logic [9:0] Y_MAX        = 10'd479,
    parameter logic [9:0] STEP         = 10'd1,
    parameter logic [9:0] WIDTH        = 10'd32,
    parameter logic [9:0] HEIGHT       = 10'd32,
    parameter logic [7:0] KEY_UP       = 8'h1A,
    parameter logic [7:0] KEY_DOWN     = 8'h16,
    parameter logic [7:0] KEY_LEFT     = 8'h04,
    parameter logic [7:0] KEY_RIGHT    = 8'h07,
    parameter logic [7:0] KEY_FIRE     = 8'h58,
    parameter logic [5:0] COOLDOWN     = 6'd30,
    parameter logic [6:0] DEATH_FRAMES = 7'd60,
    parameter logic [1:0] LIVES        = 2'd3
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic [7:0] keycode,
    input  logic       hit,
    output logic       is_tank,
    output logic [2:0] tank_dir,
    output logic [9:0] tank_X,
    output logic [9:0] tank_Y,
    output logic       fire,
    output logic [1:0] lives,
    output logic       game_over
);

    typedef enum logic [1:0] {ST_ALIVE, ST_DYING, ST_DEAD} state_t;

    state_t     r_state, w_state_nxt;
    logic       r_fc_s1, r_fc_s2, r_fc_d;
    logic       w_tick, w_hit;
    logic [9:0] r_x, r_y;
    logic [2:0] r_dir;
    logic       r_fire;
    logic [1:0] r_lives;
    logic       r_go;
    logic [5:0] r_cool;
    logic [6:0] r_dcnt;
    logic       r_hit_pend;

    logic [9:0]  w_x_nxt, w_y_nxt;
    logic [2:0]  w_dir_nxt;
    logic [10:0] w_x_ext, w_y_ext, w_x_lo, w_y_lo, w_x_hi, w_y_hi;
    logic [10:0] w_x_inc, w_y_inc;
    logic        w_in_x, w_in_y;

    assign w_tick = r_fc_s2 & ~r_fc_d;
    // A hit landing on the tick cycle itself counts for that tick.
    assign w_hit  = r_hit_pend | hit;

    assign w_x_ext = {1'b0, r_x};
    assign w_y_ext = {1'b0, r_y};
    assign w_x_lo  = {1'b0, X_MIN} + {1'b0, STEP};
    assign w_y_lo  = {1'b0, Y_MIN} + {1'b0, STEP};
    assign w_x_hi  = {1'b0, X_MAX} - {1'b0, WIDTH} + 11'd1;
    assign w_y_hi  = {1'b0, Y_MAX} - {1'b0, HEIGHT} + 11'd1;
    assign w_x_inc = w_x_ext + {1'b0, STEP};
    assign w_y_inc = w_y_ext + {1'b0, STEP};

    // Synchronise frame_clk into Clk and keep a delayed copy for edge detect
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_fc_s1 <= 1'b0;
            r_fc_s2 <= 1'b0;
            r_fc_d  <= 1'b0;
        end else begin
            r_fc_s1 <= frame_clk;
            r_fc_s2 <= r_fc_s1;
            r_fc_d  <= r_fc_s2;
        end
    end

    // Life/death state register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) r_state <= ST_ALIVE;
        else        r_state <= w_state_nxt;
    end

    // Next-state: transitions only on a frame tick
    always_comb begin
        w_state_nxt = r_state;
        if (w_tick) begin
            case (r_state)
                ST_ALIVE: if (w_hit) w_state_nxt = ST_DYING;
                ST_DYING: if (r_dcnt == '0)
                              w_state_nxt = (r_lives == '0) ? ST_DEAD : ST_ALIVE;
                default:  w_state_nxt = r_state;
            endcase
        end
    end

    // Decode direction key into clamped candidate position and heading
    always_comb begin
        w_x_nxt   = r_x;
        w_y_nxt   = r_y;
        w_dir_nxt = r_dir;
        if (keycode == KEY_UP) begin
            w_dir_nxt = 3'b001;
            w_y_nxt   = (w_y_ext < w_y_lo) ? Y_MIN : r_y - STEP;
        end else if (keycode == KEY_DOWN) begin
            w_dir_nxt = 3'b100;
            w_y_nxt   = (w_y_inc > w_y_hi) ? w_y_hi[9:0] : w_y_inc[9:0];
        end else if (keycode == KEY_LEFT) begin
            w_dir_nxt = 3'b011;
            w_x_nxt   = (w_x_ext < w_x_lo) ? X_MIN : r_x - STEP;
        end else if (keycode == KEY_RIGHT) begin
            w_dir_nxt = 3'b010;
            w_x_nxt   = (w_x_inc > w_x_hi) ? w_x_hi[9:0] : w_x_inc[9:0];
        end
    end

    // Per-tick game datapath: hit latch, motion, fire/cooldown, lives, respawn
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_x        <= X_START;
            r_y        <= Y_START;
            r_dir      <= 3'b001;
            r_fire     <= 1'b0;
            r_lives    <= LIVES;
            r_go       <= 1'b0;
            r_cool     <= '0;
            r_dcnt     <= '0;
            r_hit_pend <= 1'b0;
        end else begin
            r_fire <= 1'b0;
            if (r_state == ST_ALIVE && hit) r_hit_pend <= 1'b1;
            if (w_tick) begin
                r_hit_pend <= 1'b0;
                case (r_state)
                    ST_ALIVE: begin
                        if (r_cool != '0) r_cool <= r_cool - 6'd1;
                        if (w_hit) begin
                            r_lives <= r_lives - 2'd1;
                            r_dcnt  <= DEATH_FRAMES - 7'd1;
                        end else if (keycode == KEY_FIRE && r_cool == '0) begin
                            r_fire <= 1'b1;
                            r_cool <= COOLDOWN;
                        end else begin
                            r_x   <= w_x_nxt;
                            r_y   <= w_y_nxt;
                            r_dir <= w_dir_nxt;
                        end
                    end
                    ST_DYING: begin
                        if (r_dcnt == '0) begin
                            if (r_lives == '0) begin
                                r_go <= 1'b1;
                            end else begin
                                r_x    <= X_START;
                                r_y    <= Y_START;
                                r_dir  <= 3'b001;
                                r_cool <= '0;
                            end
                        end else begin
                            r_dcnt <= r_dcnt - 7'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign w_in_x = ({1'b0, DrawX} >= w_x_ext) &&
                    ({1'b0, DrawX} <= w_x_ext + {1'b0, WIDTH} - 11'd1);
    assign w_in_y = ({1'b0, DrawY} >= w_y_ext) &&
                    ({1'b0, DrawY} <= w_y_ext + {1'b0, HEIGHT} - 11'd1);

    // Hit-box visibility gated by life state; dying blinks on counter bit 2
    always_comb begin
        case (r_state)
            ST_ALIVE: is_tank = w_in_x & w_in_y;
            ST_DYING: is_tank = w_in_x & w_in_y & r_dcnt[2];
            default:  is_tank = 1'b0;
        endcase
    end

    assign tank_X    = r_x;
    assign tank_Y    = r_y;
    assign tank_dir  = r_dir;
    assign fire      = r_fire;
    assign lives     = r_lives;
    assign game_over = r_go;

endmodule

// File: tb/tb_tank_ctrl_p.sv
// Scoreboard bench for tank_ctrl_p: stimulus pushes hand-computed expected
// states and fire-tick indices; a monitor pops and compares at negedge Clk.
module tb_tank_ctrl_p;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic [9:0] DrawX = '0;
    logic [9:0] DrawY = '0;
    logic [7:0] keycode = '0;
    logic       hit = 1'b0;
    logic       is_tank;
    logic [2:0] tank_dir;
    logic [9:0] tank_X, tank_Y;
    logic       fire;
    logic [1:0] lives;
    logic       game_over;

    tank_ctrl_p dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .keycode   (keycode),
        .hit       (hit),
        .is_tank   (is_tank),
        .tank_dir  (tank_dir),
        .tank_X    (tank_X),
        .tank_Y    (tank_Y),
        .fire      (fire),
        .lives     (lives),
        .game_over (game_over)
    );

    always #10 Clk = ~Clk;

    typedef struct {
        string      name;
        logic [9:0] x, y;
        logic [2:0] dir;
        logic [1:0] lv;
        logic       go;
        logic       tk;
    } exp_t;

    exp_t chk_q[$];
    int   fire_q[$];
    int   n_assert = 0;
    int   n_fail = 0;
    int   frame_idx = 0;
    int   fires_seen = 0;
    logic fire_prev = 1'b0;

    task automatic cmp(input string nm, input string fld,
                       input logic [31:0] act, input logic [31:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, req);
        end
    endtask

    // Monitor: compares queued expectations and every fire pulse
    initial begin
        exp_t e;
        int   ft;
        forever begin
            @(negedge Clk);
            while (chk_q.size() > 0) begin
                e = chk_q.pop_front();
                cmp(e.name, "tank_X",    tank_X,    e.x);
                cmp(e.name, "tank_Y",    tank_Y,    e.y);
                cmp(e.name, "tank_dir",  tank_dir,  e.dir);
                cmp(e.name, "lives",     lives,     e.lv);
                cmp(e.name, "game_over", game_over, e.go);
                cmp(e.name, "is_tank",   is_tank,   e.tk);
            end
            if (fire === 1'b1) begin
                fires_seen++;
                cmp("fire", "width", fire_prev, 0);
                if (fire_q.size() == 0) begin
                    cmp("fire", "unexpected", fire, 0);
                end else begin
                    ft = fire_q.pop_front();
                    cmp("fire", "tick", frame_idx, ft);
                end
            end
            fire_prev = fire;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic frames(input int n);
        repeat (n) begin
            frame_clk = 1'b1;
            frame_idx++;
            repeat (4) @(posedge Clk);
            #1;
            frame_clk = 1'b0;
            repeat (4) @(posedge Clk);
            #1;
        end
    endtask

    task automatic hit_pulse();
        hit = 1'b1;
        @(posedge Clk);
        #1;
        hit = 1'b0;
    endtask

    task automatic check(input string nm, input int x, input int y, input int dir,
                         input int lv, input int go, input int dx, input int dy,
                         input int tk);
        exp_t e;
        DrawX  = dx[9:0];
        DrawY  = dy[9:0];
        e.name = nm;
        e.x    = x[9:0];
        e.y    = y[9:0];
        e.dir  = dir[2:0];
        e.lv   = lv[1:0];
        e.go   = go[0];
        e.tk   = tk[0];
        chk_q.push_back(e);
        @(negedge Clk);
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #5 Reset = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("reset", 500, 240, 1, 3, 0, 500, 240, 1);
        Reset = 1'b1;
        @(posedge Clk); #1;

        // right 10 frames
        keycode = 8'h07;
        frames(10);
        check("right10",      510, 240, 2, 3, 0, 541, 271, 1);
        check("right10_edge", 510, 240, 2, 3, 0, 542, 271, 0);

        // saturate at X_MAX-WIDTH+1
        frames(100);
        check("right_clamp",  608, 240, 2, 3, 0, 639, 240, 1);

        keycode = 8'h04;
        frames(3);
        check("left3",        605, 240, 3, 3, 0, 605, 240, 1);

        keycode = 8'h1A;
        frames(245);
        check("up_clamp",     605, 0,   1, 3, 0, 605, 31,  1);
        check("up_clamp_bot", 605, 0,   1, 3, 0, 605, 32,  0);

        keycode = 8'h16;
        frames(1);
        check("down1",        605, 1,   4, 3, 0, 605, 0,   0);

        // fire rate limit: pulses at frames 1, 32, 63
        frame_idx = 0;
        fire_q.push_back(1);
        fire_q.push_back(32);
        fire_q.push_back(63);
        keycode = 8'h58;
        frames(65);
        check("fire_hold",    605, 1,   4, 3, 0, 605, 1,   1);

        keycode = 8'h00;
        frames(2);
        check("idle_key",     605, 1,   4, 3, 0, 636, 32,  1);

        // hit while moving
        keycode = 8'h07;
        frames(1);
        check("move_pre_hit", 606, 1,   2, 3, 0, 606, 1,   1);
        repeat (3) @(posedge Clk);
        #1;
        hit_pulse();
        frames(1);
        check("hit1_dying",   606, 1,   2, 2, 0, 606, 1,   0);
        frames(4);
        check("hit1_blink",   606, 1,   2, 2, 0, 606, 1,   1);
        hit_pulse();
        frames(55);
        check("hit1_pre_resp", 606, 1,  2, 2, 0, 606, 1,   0);
        frames(1);
        keycode = 8'h00;
        check("respawn1",     500, 240, 1, 2, 0, 500, 240, 1);
        frames(1);
        check("alive_after_dying_hit", 500, 240, 1, 2, 0, 531, 271, 1);

        // hit and fire on the same tick: hit wins, no fire
        keycode = 8'h58;
        hit_pulse();
        frames(1);
        keycode = 8'h00;
        check("hit2_fire",    500, 240, 1, 1, 0, 500, 240, 0);
        frames(60);
        check("respawn2",     500, 240, 1, 1, 0, 500, 240, 1);

        // third life lost -> game over
        hit_pulse();
        frames(1);
        check("hit3_dying",   500, 240, 1, 0, 0, 500, 240, 0);
        frames(60);
        check("dead",         500, 240, 1, 0, 1, 500, 240, 0);
        keycode = 8'h07;
        hit_pulse();
        frames(3);
        keycode = 8'h58;
        frames(3);
        check("dead_frozen",  500, 240, 1, 0, 1, 510, 250, 0);

        // reset from DEAD
        keycode = 8'h00;
        Reset = 1'b0;
        #1;
        check("reset_dead",   500, 240, 1, 3, 0, 500, 240, 1);
        Reset = 1'b1;
        @(posedge Clk); #1;

        // asynchronous reset mid-DYING
        keycode = 8'h07;
        frames(2);
        keycode = 8'h00;
        check("move2",        502, 240, 2, 3, 0, 533, 240, 1);
        hit_pulse();
        frames(5);
        check("dying_blink",  502, 240, 2, 2, 0, 502, 240, 1);
        #2;
        Reset = 1'b0;
        check("async_reset",  500, 240, 1, 3, 0, 500, 240, 1);
        Reset = 1'b1;

        repeat (3) @(posedge Clk);
        #1;
        cmp("fire", "pending", fire_q.size(), 0);
        cmp("fire", "count", fires_seen, 3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
